// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and access-size helpers for the sized data memory
package dmem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } mem_funct3_e;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_e;

    // Byte enables for a store; unknown encodings touch no lanes.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
        logic [3:0] mask;
        case (funct3)
            F3_B, F3_BU: mask = 4'b0001 << offset;
            F3_H, F3_HU: mask = offset[1] ? 4'b1100 : 4'b0011;
            F3_W:        mask = 4'b1111;
            default:     mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Also flags the reserved funct3 encodings so one signal gates every error.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic bad;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = offset[0];
            F3_W:        bad = (offset != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - lane select and sign/zero extension of a loaded word
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign shifted = word >> {offset, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data = {24'h0, byte_v};
            F3_H:    data = {{16{half_v[15]}}, half_v};
            F3_HU:   data = {16'h0, half_v};
            F3_W:    data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - byte-addressed data memory with sized access, handshake and post-reset clear
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_SIZE       = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  rd_valid,
    output logic                  err,
    output logic                  busy
);

    localparam int IDX_W = $clog2(MEM_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_SIZE - 1);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_width
            $error("data_memory_sized: DATA_WIDTH must be 32");
        end
    endgenerate

    state_e                  state;
    logic [IDX_W-1:0]        clr_idx;
    logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];

    logic                    accept;
    logic                    bad;
    logic [IDX_W-1:0]        idx;
    logic [1:0]              off;
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   wd_rep;
    logic [DATA_WIDTH-1:0]   ld_data;
    logic                    unused_addr_bits;

    assign accept = req_valid && req_ready;
    assign idx    = A[IDX_W+1:2];
    assign off    = A[1:0];
    assign bad    = is_misaligned(req_funct3, off);
    assign be     = lane_mask(req_funct3, off);

    // Upper address bits are deliberately dropped so accesses wrap.
    assign unused_addr_bits = ^A[ADDR_WIDTH-1:IDX_W+2];

    always_comb begin
        wd_rep = WD;
        case (req_funct3)
            F3_B, F3_BU: wd_rep = {4{WD[7:0]}};
            F3_H, F3_HU: wd_rep = {2{WD[15:0]}};
            default:     wd_rep = WD;
        endcase
    end

    dmem_load_align u_align (
        .word   (mem[idx]),
        .offset (off),
        .funct3 (req_funct3),
        .data   (ld_data)
    );

    // Array has no reset; req_ready is low during reset so no request writes it then.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (accept && req_we && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wd_rep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_idx   <= '0;
            busy      <= (CLEAR_ON_RESET != 0);
            req_ready <= 1'b0;
            RD        <= '0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            rd_valid <= accept && !req_we;
            err      <= accept && bad;
            if (accept && !req_we) begin
                RD <= bad ? '0 : ld_data;
            end
            case (state)
                ST_CLEAR: begin
                    clr_idx   <= clr_idx + 1'b1;
                    busy      <= 1'b1;
                    req_ready <= 1'b0;
                    if (clr_idx == LAST_IDX) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
